// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: frames a byte stream (operand 1, operand 2, opcode) into
// registered ALU inputs, captures the combinational ALU result and hands it
// out on a valid/ready port with backpressure. Partial frames are dropped
// after TIMEOUT idle cycles (TIMEOUT == 0 disables the abort).
// Optional build macro: ALU_OPCODE_CHECK_EN (illegal opcodes give result 0
// and o_err = 1).
module alu_seq_ctrl #(
   parameter int unsigned NB_DATA = 8,
   parameter int unsigned NB_OP   = 6,
   parameter int unsigned NB_TMO  = 16,
   parameter int unsigned TIMEOUT = 1000
) (
   input  logic               i_clock,
   input  logic               i_reset,
   input  logic [NB_DATA-1:0] i_data,
   input  logic               i_valid,
   output logic               o_ready,
   output logic [NB_DATA-1:0] o_alu_ope1,
   output logic [NB_DATA-1:0] o_alu_ope2,
   output logic [NB_OP-1:0]   o_alu_opcode,
   input  logic [NB_DATA-1:0] i_alu_result,
   output logic [NB_DATA-1:0] o_result,
   output logic               o_result_valid,
   input  logic               i_result_ready,
   output logic               o_err,
   output logic               o_timeout
);

   typedef enum logic [2:0] {
      S_A    = 3'd0,
      S_B    = 3'd1,
      S_OP   = 3'd2,
      S_EXEC = 3'd3,
      S_OUT  = 3'd4
   } state_t;

   // Last idle count before a partial frame is aborted.
   localparam logic [NB_TMO-1:0] TMO_LAST =
      (TIMEOUT == 0) ? '0 : NB_TMO'(TIMEOUT - 1);
   localparam logic TMO_EN = (TIMEOUT != 0);

   state_t              r_state;
   logic                r_ready;
   logic [NB_DATA-1:0]  r_ope1;
   logic [NB_DATA-1:0]  r_ope2;
   logic [NB_OP-1:0]    r_opcode;
   logic [NB_DATA-1:0]  r_result;
   logic                r_result_valid;
   logic                r_err;
   logic                r_timeout;
   logic [NB_TMO-1:0]   r_tmo_cnt;

   logic                w_xfer;
   logic                w_tmo_hit;

`ifdef ALU_OPCODE_CHECK_EN
   logic                r_op_legal;

   // Legal opcode set of the downstream ALU.
   function automatic logic is_legal(input logic [NB_OP-1:0] op);
      case (op)
         NB_OP'(6'b100000), NB_OP'(6'b100010), NB_OP'(6'b100100),
         NB_OP'(6'b100101), NB_OP'(6'b100110), NB_OP'(6'b000011),
         NB_OP'(6'b000010), NB_OP'(6'b100111): is_legal = 1'b1;
         default:                              is_legal = 1'b0;
      endcase
   endfunction
`endif

   assign w_xfer    = i_valid && r_ready;
   assign w_tmo_hit = TMO_EN && !w_xfer && (r_tmo_cnt == TMO_LAST);

   // Frame sequencer, result capture and idle-timeout counter.
   always_ff @(posedge i_clock) begin
      if (!i_reset) begin
         r_state        <= S_A;
         r_ready        <= 1'b1;
         r_ope1         <= '0;
         r_ope2         <= '0;
         r_opcode       <= '0;
         r_result       <= '0;
         r_result_valid <= 1'b0;
         r_err          <= 1'b0;
         r_timeout      <= 1'b0;
         r_tmo_cnt      <= '0;
`ifdef ALU_OPCODE_CHECK_EN
         r_op_legal     <= 1'b0;
`endif
      end else begin
         r_timeout <= 1'b0;
         case (r_state)
            S_A: begin
               r_tmo_cnt <= '0;
               if (w_xfer) begin
                  r_ope1  <= i_data;
                  r_state <= S_B;
               end
            end
            S_B: begin
               if (w_xfer) begin
                  r_ope2    <= i_data;
                  r_tmo_cnt <= '0;
                  r_state   <= S_OP;
               end else if (w_tmo_hit) begin
                  r_tmo_cnt <= '0;
                  r_timeout <= 1'b1;
                  r_state   <= S_A;
               end else if (TMO_EN) begin
                  r_tmo_cnt <= r_tmo_cnt + NB_TMO'(1);
               end
            end
            S_OP: begin
               if (w_xfer) begin
                  r_opcode  <= i_data[NB_OP-1:0];
`ifdef ALU_OPCODE_CHECK_EN
                  r_op_legal <= is_legal(i_data[NB_OP-1:0]);
`endif
                  r_tmo_cnt <= '0;
                  r_ready   <= 1'b0;
                  r_state   <= S_EXEC;
               end else if (w_tmo_hit) begin
                  r_tmo_cnt <= '0;
                  r_timeout <= 1'b1;
                  r_state   <= S_A;
               end else if (TMO_EN) begin
                  r_tmo_cnt <= r_tmo_cnt + NB_TMO'(1);
               end
            end
            S_EXEC: begin
               r_tmo_cnt      <= '0;
`ifdef ALU_OPCODE_CHECK_EN
               if (r_op_legal) begin
                  r_result <= i_alu_result;
                  r_err    <= 1'b0;
               end else begin
                  r_result <= '0;
                  r_err    <= 1'b1;
               end
`else
               r_result       <= i_alu_result;
               r_err          <= 1'b0;
`endif
               r_result_valid <= 1'b1;
               r_state        <= S_OUT;
            end
            S_OUT: begin
               r_tmo_cnt <= '0;
               if (i_result_ready) begin
                  r_result_valid <= 1'b0;
                  r_ready        <= 1'b1;
                  r_state        <= S_A;
               end
            end
            default: begin
               r_tmo_cnt      <= '0;
               r_result_valid <= 1'b0;
               r_ready        <= 1'b1;
               r_state        <= S_A;
            end
         endcase
      end
   end

   assign o_ready        = r_ready;
   assign o_alu_ope1     = r_ope1;
   assign o_alu_ope2     = r_ope2;
   assign o_alu_opcode   = r_opcode;
   assign o_result       = r_result;
   assign o_result_valid = r_result_valid;
   assign o_err          = r_err;
   assign o_timeout      = r_timeout;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl with a behavioural ALU on the ALU ports.
module tb_alu_seq_ctrl;

   localparam int unsigned NB_DATA = 8;
   localparam int unsigned NB_OP   = 6;
   localparam int unsigned NB_TMO  = 16;
   localparam int unsigned TIMEOUT = 8;

   logic               clk = 1'b0;
   logic               i_reset;
   logic [NB_DATA-1:0] i_data;
   logic               i_valid;
   logic               o_ready;
   logic [NB_DATA-1:0] o_alu_ope1;
   logic [NB_DATA-1:0] o_alu_ope2;
   logic [NB_OP-1:0]   o_alu_opcode;
   logic [NB_DATA-1:0] w_alu_result;
   logic [NB_DATA-1:0] o_result;
   logic               o_result_valid;
   logic               i_result_ready;
   logic               o_err;
   logic               o_timeout;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   alu_seq_ctrl #(
      .NB_DATA(NB_DATA), .NB_OP(NB_OP), .NB_TMO(NB_TMO), .TIMEOUT(TIMEOUT)
   ) dut (
      .i_clock        (clk),
      .i_reset        (i_reset),
      .i_data         (i_data),
      .i_valid        (i_valid),
      .o_ready        (o_ready),
      .o_alu_ope1     (o_alu_ope1),
      .o_alu_ope2     (o_alu_ope2),
      .o_alu_opcode   (o_alu_opcode),
      .i_alu_result   (w_alu_result),
      .o_result       (o_result),
      .o_result_valid (o_result_valid),
      .i_result_ready (i_result_ready),
      .o_err          (o_err),
      .o_timeout      (o_timeout)
   );

   // Behavioural ALU; unknown opcodes return A5 so a zeroed result is visible.
   function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                        input logic [5:0] op);
      case (op)
         6'h20:   alu_f = a + b;
         6'h22:   alu_f = a - b;
         6'h24:   alu_f = a & b;
         6'h25:   alu_f = a | b;
         6'h26:   alu_f = a ^ b;
         6'h03:   alu_f = 8'($signed(a) >>> b);
         6'h02:   alu_f = a >> b;
         6'h27:   alu_f = ~(a | b);
         default: alu_f = 8'hA5;
      endcase
   endfunction

   assign w_alu_result = alu_f(o_alu_ope1, o_alu_ope2, o_alu_opcode);

   // Present one byte and hold it until the edge that transfers it.
   task automatic send_byte(input logic [7:0] b, output bit ok);
      int n;
      n = 0;
      i_data  = b;
      i_valid = 1'b1;
      while (o_ready !== 1'b1 && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      ok = (n < 20);
      @(posedge clk); #1;
      i_valid = 1'b0;
   endtask

   task automatic send_frame(input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] op, output bit ok);
      bit k1, k2, k3;
      send_byte(a, k1);
      send_byte(b, k2);
      send_byte(op, k3);
      ok = k1 && k2 && k3;
   endtask

   // Advance until o_result_valid is seen, bounded.
   task automatic wait_valid();
      int n;
      n = 0;
      while (o_result_valid !== 1'b1 && n < 12) begin
         @(posedge clk); #1;
         n++;
      end
   endtask

   task automatic test_reset();
      i_reset = 1'b0; i_valid = 1'b0; i_data = '0; i_result_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      total++;
      if ({o_alu_ope1, o_alu_ope2, o_alu_opcode, o_result} !== 30'd0) begin
         bad++;
         $display("FAIL reset_ports got %h want 0",
                  {o_alu_ope1, o_alu_ope2, o_alu_opcode, o_result});
      end
      total++;
      if ({o_ready, o_result_valid, o_err, o_timeout} !== 4'b1000) begin
         bad++;
         $display("FAIL reset_flags got %b want 1000",
                  {o_ready, o_result_valid, o_err, o_timeout});
      end
      i_reset = 1'b1;
   endtask

   task automatic test_add_sub();
      bit ok;
      i_result_ready = 1'b1;
      send_frame(8'hF1, 8'hF2, 8'h20, ok);
      total++;
      if (o_result_valid !== 1'b0 || !ok) begin
         bad++;
         $display("FAIL add_exec_cycle got valid=%b ok=%b want 0/1", o_result_valid, ok);
      end
      @(posedge clk); #1;
      total++;
      if ({o_result_valid, o_result, o_err} !== {1'b1, 8'hE3, 1'b0}) begin
         bad++;
         $display("FAIL add_result got v=%b r=%h e=%b want 1 E3 0",
                  o_result_valid, o_result, o_err);
      end
      send_frame(8'hF1, 8'hF2, 8'h22, ok);
      wait_valid();
      total++;
      if ({o_result_valid, o_result, o_err} !== {1'b1, 8'hFF, 1'b0}) begin
         bad++;
         $display("FAIL sub_result got v=%b r=%h e=%b want 1 FF 0",
                  o_result_valid, o_result, o_err);
      end
   endtask

   task automatic test_xor_nor();
      bit ok;
      send_frame(8'h01, 8'h0F, 8'h26, ok);
      wait_valid();
      total++;
      if ({o_result_valid, o_result} !== {1'b1, 8'h0E}) begin
         bad++;
         $display("FAIL xor_result got v=%b r=%h want 1 0E", o_result_valid, o_result);
      end
      send_frame(8'h01, 8'h0F, 8'h27, ok);
      wait_valid();
      total++;
      if ({o_result_valid, o_result} !== {1'b1, 8'hF0}) begin
         bad++;
         $display("FAIL nor_result got v=%b r=%h want 1 F0", o_result_valid, o_result);
      end
      @(posedge clk); #1;
      total++;
      if ({o_result_valid, o_alu_ope1, o_alu_ope2, o_alu_opcode} !==
          {1'b0, 8'h01, 8'h0F, 6'h27}) begin
         bad++;
         $display("FAIL alu_ports_hold got v=%b %h %h %h want 0 01 0F 27",
                  o_result_valid, o_alu_ope1, o_alu_ope2, o_alu_opcode);
      end
   endtask

   task automatic test_backpressure();
      bit ok;
      i_result_ready = 1'b0;
      send_frame(8'h01, 8'h0F, 8'h25, ok);
      wait_valid();
      for (int c = 0; c < 6; c++) begin
         total++;
         if ({o_result_valid, o_ready, o_result} !== {1'b1, 1'b0, 8'h0F}) begin
            bad++;
            $display("FAIL bp_hold cyc=%0d got v=%b rdy=%b r=%h want 1 0 0F",
                     c, o_result_valid, o_ready, o_result);
         end
         @(posedge clk); #1;
      end
      i_result_ready = 1'b1;
      @(posedge clk); #1;
      total++;
      if ({o_result_valid, o_ready} !== 2'b01) begin
         bad++;
         $display("FAIL bp_release got v=%b rdy=%b want 0 1", o_result_valid, o_ready);
      end
      send_frame(8'h0C, 8'h0A, 8'h24, ok);
      wait_valid();
      total++;
      if ({o_result_valid, o_result} !== {1'b1, 8'h08}) begin
         bad++;
         $display("FAIL bp_next_frame got v=%b r=%h want 1 08", o_result_valid, o_result);
      end
   endtask

   task automatic test_timeout();
      bit ok;
      send_byte(8'h55, ok);
      repeat (7) @(posedge clk);
      #1;
      total++;
      if ({o_timeout, o_ready} !== 2'b01) begin
         bad++;
         $display("FAIL tmo_early got tmo=%b rdy=%b want 0 1", o_timeout, o_ready);
      end
      @(posedge clk); #1;
      total++;
      if (o_timeout !== 1'b1) begin
         bad++;
         $display("FAIL tmo_pulse got %b want 1", o_timeout);
      end
      @(posedge clk); #1;
      total++;
      if (o_timeout !== 1'b0) begin
         bad++;
         $display("FAIL tmo_one_cycle got %b want 0", o_timeout);
      end
      send_frame(8'h05, 8'h03, 8'h20, ok);
      wait_valid();
      total++;
      if ({o_result_valid, o_result, o_alu_ope1} !== {1'b1, 8'h08, 8'h05}) begin
         bad++;
         $display("FAIL tmo_fresh_frame got v=%b r=%h ope1=%h want 1 08 05",
                  o_result_valid, o_result, o_alu_ope1);
      end
   endtask

   task automatic test_timeout_priority();
      bit ok;
      send_byte(8'h55, ok);
      repeat (7) @(posedge clk);
      #1;
      send_byte(8'h66, ok);
      total++;
      if (o_timeout !== 1'b0) begin
         bad++;
         $display("FAIL tmo_priority got tmo=%b want 0", o_timeout);
      end
      send_byte(8'h20, ok);
      wait_valid();
      total++;
      if ({o_result_valid, o_result} !== {1'b1, 8'hBB}) begin
         bad++;
         $display("FAIL tmo_priority_result got v=%b r=%h want 1 BB",
                  o_result_valid, o_result);
      end
   endtask

   task automatic test_reset_mid();
      bit ok;
      @(posedge clk); #1;
      send_byte(8'h11, ok);
      send_byte(8'h22, ok);
      i_reset = 1'b0;
      @(posedge clk); #1;
      i_reset = 1'b1;
      total++;
      if ({o_alu_ope1, o_alu_ope2, o_alu_opcode, o_result} !== 30'd0) begin
         bad++;
         $display("FAIL midreset_ports got %h want 0",
                  {o_alu_ope1, o_alu_ope2, o_alu_opcode, o_result});
      end
      total++;
      if ({o_ready, o_result_valid, o_err, o_timeout} !== 4'b1000) begin
         bad++;
         $display("FAIL midreset_flags got %b want 1000",
                  {o_ready, o_result_valid, o_err, o_timeout});
      end
      send_frame(8'h02, 8'h03, 8'h20, ok);
      wait_valid();
      total++;
      if ({o_result_valid, o_result} !== {1'b1, 8'h05}) begin
         bad++;
         $display("FAIL midreset_frame got v=%b r=%h want 1 05", o_result_valid, o_result);
      end
   endtask

   task automatic test_opcode_check();
      bit ok;
      logic [7:0] exp_r;
      logic       exp_e;
`ifdef ALU_OPCODE_CHECK_EN
      exp_r = 8'h00; exp_e = 1'b1;
`else
      exp_r = 8'hA5; exp_e = 1'b0;
`endif
      send_frame(8'hAA, 8'h55, 8'h3F, ok);
      wait_valid();
      total++;
      if ({o_result_valid, o_result, o_err} !== {1'b1, exp_r, exp_e}) begin
         bad++;
         $display("FAIL illegal_op got v=%b r=%h e=%b want 1 %h %b",
                  o_result_valid, o_result, o_err, exp_r, exp_e);
      end
      send_frame(8'hAA, 8'h55, 8'h24, ok);
      wait_valid();
      total++;
      if ({o_result_valid, o_result, o_err} !== {1'b1, 8'h00, 1'b0}) begin
         bad++;
         $display("FAIL legal_and got v=%b r=%h e=%b want 1 00 0",
                  o_result_valid, o_result, o_err);
      end
   endtask

   task automatic test_opcode_bits();
      bit ok;
      send_frame(8'h10, 8'h20, 8'hE0, ok);
      wait_valid();
      total++;
      if ({o_result_valid, o_result, o_alu_opcode} !== {1'b1, 8'h30, 6'h20}) begin
         bad++;
         $display("FAIL opcode_upper_bits got v=%b r=%h op=%h want 1 30 20",
                  o_result_valid, o_result, o_alu_opcode);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] q [6];
      int         idx, t1, t2;
      logic [7:0] r1, r2;
      logic       rdy;
      q[0] = 8'h03; q[1] = 8'h04; q[2] = 8'h20;
      q[3] = 8'h0A; q[4] = 8'h05; q[5] = 8'h22;
      idx = 0; t1 = -1; t2 = -1; r1 = '0; r2 = '0;
      i_result_ready = 1'b1;
      @(posedge clk); #1;
      for (int cyc = 0; cyc < 30; cyc++) begin
         if (idx < 6) begin
            i_data  = q[idx];
            i_valid = 1'b1;
         end else begin
            i_valid = 1'b0;
         end
         rdy = o_ready;
         @(posedge clk); #1;
         if (rdy && idx < 6) idx++;
         if (o_result_valid === 1'b1) begin
            if (t1 < 0) begin
               t1 = cyc; r1 = o_result;
            end else if (t2 < 0) begin
               t2 = cyc; r2 = o_result;
            end
         end
      end
      i_valid = 1'b0;
      total++;
      if (t1 < 0 || t2 - t1 != 5) begin
         bad++;
         $display("FAIL b2b_period got t1=%0d t2=%0d want spacing 5", t1, t2);
      end
      total++;
      if ({r1, r2} !== {8'h07, 8'h05}) begin
         bad++;
         $display("FAIL b2b_results got %h %h want 07 05", r1, r2);
      end
   endtask

   initial begin
      test_reset();
      test_add_sub();
      test_xor_nor();
      test_backpressure();
      test_timeout();
      test_timeout_priority();
      test_reset_mid();
      test_opcode_check();
      test_opcode_bits();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
